// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute stage behind the operand-select logic.
// Takes an operand pair and op code under a valid/ready handshake, computes
// the result with carry/zero/sign flags, and holds them under a second
// valid/ready handshake until writeback/branch logic takes them.
// Shifts run one bit per cycle by default.
// Build option: define FAST_SHIFT_EN for a single-cycle barrel shifter.
// Results and flags are identical in both builds; only timing differs.
module alu_exec_unit #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             sign
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_COMP = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_XOR  = 4'd3;
  localparam logic [3:0] OP_SHLL = 4'd4;
  localparam logic [3:0] OP_SHRL = 4'd5;
  localparam logic [3:0] OP_SHRA = 4'd6;

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             sign_q, sign_d;

  logic             accept;
  logic [SHW-1:0]   amt;
  logic [WIDTH:0]   wide;

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid && in_ready;
  assign amt       = input2[SHW-1:0];

  // Next-state, work register (result_q doubles as the shift register) and flags
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    sign_d   = sign_q;
    wide     = '0;

    if (state_q == DONE && out_ready) state_d = IDLE;

    if (state_q == SHIFT) begin
      case (op_q)
        OP_SHLL: {carry_d, result_d} = {result_q, 1'b0};
        OP_SHRL: {result_d, carry_d} = {1'b0, result_q};
        default: {result_d, carry_d} = {result_q[WIDTH-1], result_q};
      endcase
      cnt_d = cnt_q - SHW'(1);
      if (cnt_q == SHW'(1)) state_d = DONE;
    end

    // A new op overrides the DONE->IDLE drain: the old result is consumed
    if (accept) begin
      op_d    = op;
      state_d = DONE;
      carry_d = 1'b0;
      case (op)
        OP_ADD: begin
          wide = {1'b0, input1} + {1'b0, input2};
          {carry_d, result_d} = wide;
        end
        OP_COMP: begin
          result_d = (~input2) + WIDTH'(1);
          carry_d  = (input2 == '0);
        end
        OP_AND: result_d = input1 & input2;
        OP_XOR: result_d = input1 ^ input2;
        OP_SHLL, OP_SHRL, OP_SHRA: begin
          result_d = input1;
          if (amt != '0) begin
`ifdef FAST_SHIFT_EN
            // One guard bit beside the operand catches the last bit shifted out
            case (op)
              OP_SHLL: begin
                wide = {1'b0, input1} << amt;
                {carry_d, result_d} = wide;
              end
              OP_SHRL: begin
                wide = {input1, 1'b0} >> amt;
                {result_d, carry_d} = wide;
              end
              default: begin
                wide = $signed({input1, 1'b0}) >>> amt;
                {result_d, carry_d} = wide;
              end
            endcase
`else
            cnt_d   = amt;
            state_d = SHIFT;
`endif
          end
        end
        default: result_d = input1;
      endcase
    end

    // Flags track the result only once it is final
    if (state_d == DONE) begin
      zero_d = (result_d == '0);
      sign_d = result_d[WIDTH-1];
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      sign_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      sign_q   <= sign_d;
    end
  end

  assign result = result_q;
  assign carry  = carry_q;
  assign zero   = zero_q;
  assign sign   = sign_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Testbench for alu_exec_unit: directed vector table, hand-written handshake
// sequences (stall, back-to-back, reset mid-shift) and random ops checked
// against a plain-arithmetic reference model.
module tb_alu_exec_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready;
  logic [3:0]   op;
  logic [W-1:0] input1, input2;
  logic         out_valid, out_ready;
  logic [W-1:0] result;
  logic         carry, zero, sign;

  int n_chk  = 0;
  int n_fail = 0;

  alu_exec_unit #(.WIDTH(W), .SHW(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .input1(input1), .input2(input2),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry(carry), .zero(zero), .sign(sign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_r;
    logic         exp_c;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model straight from the op definitions
  task automatic model(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] r, output logic c);
    int n;
    longint unsigned s;
    n = int'(b[4:0]);
    c = 1'b0;
    case (o)
      4'd0: begin s = longint'(a) + longint'(b); r = s[W-1:0]; c = s[W]; end
      4'd1: begin r = 32'd0 - b; c = (b == 0); end
      4'd2: r = a & b;
      4'd3: r = a ^ b;
      4'd4: begin r = a << n; if (n != 0) c = a[W-n]; end
      4'd5: begin r = a >> n; if (n != 0) c = a[n-1]; end
      4'd6: begin r = $signed(a) >>> n; if (n != 0) c = a[n-1]; end
      default: r = a;
    endcase
  endtask

  function automatic int exp_lat(input logic [3:0] o, input logic [W-1:0] b);
`ifdef FAST_SHIFT_EN
    return 1;
`else
    if ((o == 4'd4 || o == 4'd5 || o == 4'd6) && b[4:0] != 0) return int'(b[4:0]) + 1;
    return 1;
`endif
  endfunction

  // Called at a negedge; holds the request until accepted on a posedge
  task automatic issue(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    int t;
    in_valid = 1'b1; op = o; input1 = a; input2 = b;
    t = 0;
    while (!in_ready && t < 100) begin @(negedge clk); t++; end
    check("accept_timeout", 64'(t >= 100), 64'd0);
    @(posedge clk);
  endtask

  // Counts cycles from accept to out_valid; ends on a negedge with out_valid seen
  task automatic wait_done(output int lat);
    logic busy_ready;
    busy_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    input1 = $urandom; input2 = $urandom; op = 4'($urandom);
    lat = 1;
    while (!out_valid && lat < 200) begin
      if (in_ready) busy_ready = 1'b1;
      @(negedge clk);
      lat++;
    end
    check("in_ready_while_busy", 64'(busy_ready), 64'd0);
  endtask

  task automatic run_check(input string tag, input logic [3:0] o,
                           input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] er, input logic ec);
    int lat;
    issue(o, a, b);
    wait_done(lat);
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat(o, b)));
    check({tag, "_result"}, 64'(result), 64'(er));
    check({tag, "_carry"}, 64'(carry), 64'(ec));
    check({tag, "_zero"}, 64'(zero), 64'(er == 0));
    check({tag, "_sign"}, 64'(sign), 64'(er[W-1]));
    @(negedge clk);
  endtask

  initial begin
    logic [W-1:0] mr, a, b;
    logic         mc;
    logic [3:0]   o;
    int           lat;

    vecs[0]  = '{4'd0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1};
    vecs[1]  = '{4'd6, 32'h80000000, 32'h00000004, 32'hF8000000, 1'b0};
    vecs[2]  = '{4'd4, 32'h12345678, 32'h00000000, 32'h12345678, 1'b0};
    vecs[3]  = '{4'd5, 32'h00000003, 32'h00000001, 32'h00000001, 1'b1};
    vecs[4]  = '{4'd6, 32'h80000000, 32'h0000001F, 32'hFFFFFFFF, 1'b0};
    vecs[5]  = '{4'd1, 32'h12345678, 32'h00000000, 32'h00000000, 1'b1};
    vecs[6]  = '{4'd1, 32'h00000000, 32'h00000005, 32'hFFFFFFFB, 1'b0};
    vecs[7]  = '{4'd2, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0};
    vecs[8]  = '{4'd3, 32'hAAAAAAAA, 32'hFFFFFFFF, 32'h55555555, 1'b0};
    vecs[9]  = '{4'd12, 32'hDEADBEEF, 32'h00000007, 32'hDEADBEEF, 1'b0};
    vecs[10] = '{4'd4, 32'h0000000F, 32'h00000024, 32'h000000F0, 1'b0};
    vecs[11] = '{4'd4, 32'h80000001, 32'h00000001, 32'h00000002, 1'b1};

    rst = 1'b1; in_valid = 1'b0; op = '0; input1 = '0; input2 = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_flags", 64'({carry, zero, sign}), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) run_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                                vecs[i].exp_r, vecs[i].exp_c);

    // Consumer stall: result held, no new accept until out_ready
    out_ready = 1'b0;
    issue(4'd1, 32'h0, 32'h5);
    wait_done(lat);
    check("stall_first", 64'(result), 64'hFFFFFFFB);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_result", 64'(result), 64'hFFFFFFFB);
      check("stall_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    #1 check("stall_release_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    check("stall_drain", 64'(out_valid), 64'd0);

    // Back-to-back: accept in the same cycle the old result is consumed
    issue(4'd0, 32'd1, 32'd2);
    wait_done(lat);
    check("b2b_first", 64'(result), 64'd3);
    issue(4'd0, 32'd3, 32'd4);
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b_valid", 64'(out_valid), 64'd1);
    check("b2b_result", 64'(result), 64'd7);
    @(negedge clk);
    check("b2b_no_dup", 64'(out_valid), 64'd0);

    // Reset in the middle of a long shift
    issue(4'd4, 32'd1, 32'd20);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
`ifndef FAST_SHIFT_EN
    check("midshift_busy", 64'(in_ready), 64'd0);
`endif
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_result", 64'(result), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_check("post_rst_add", 4'd0, 32'd1, 32'd1, 32'd2, 1'b0);

    // Random ops against the model, shifts weighted up
    for (int i = 0; i < 60; i++) begin
      o = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(4, 6)) : 4'($urandom);
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 1)) : $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h80000000;
      model(o, a, b, mr, mc);
      run_check($sformatf("rnd%0d_op%0d", i, o), o, a, b, mr, mc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
